frame_buffer_sram_arbiter: RTL and testbench
============================================

# frame_buffer_sram_arbiter

- Shares the single graphics frame-buffer SRAM between two requesters:
  - the VGA display fetch path (read-only, latency-critical);
  - the graphics controller drawing engine (read/write, byte-enabled).
- Sits between both requesters and the SRAM pins.
- Sequences every access through a fixed-length bus cycle and returns read data with a one-cycle acknowledge.
- Gives VGA priority, with vertical-blank override and a starvation bound for the drawing engine.

## Interface
Parameters:
- ACCESS_CYCLES, 2, cycles the SRAM bus is held per access (≥1)
- GFX_MAX_WAIT, 8, cycles a pending Gfx request may lose arbitration before it is forced to win (≥1)

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- VSync_L  in  1  low during vertical blank
- Vga_Req  in  1  display fetch request, held until Vga_Ack
- Vga_Addr  in  18  display fetch word address
- Vga_Ack  out  1  one-cycle pulse, Vga_RData valid
- Vga_RData  out  16  display read data
- Gfx_Req  in  1  drawing request, held until Gfx_Ack
- Gfx_RW  in  1  1 = read, 0 = write
- Gfx_Addr  in  18  drawing word address
- Gfx_WData  in  16  write data
- Gfx_UDS_L, Gfx_LDS_L  in  1 each  active-low byte enables
- Gfx_Ack  out  1  one-cycle pulse, access complete
- Gfx_RData  out  16  read data, valid with Gfx_Ack
- Sram_AddressOut  out  18  SRAM address
- Sram_DataOut  out  16  SRAM write data
- Sram_DataIn  in  16  SRAM read data
- Sram_UDS_Out_L, Sram_LDS_Out_L  out  1 each  SRAM byte enables
- Sram_RW_Out  out  1  1 = read, 0 = write

## Operation
States:
- IDLE:
  - selects an owner; on a grant, latches address, data, RW and byte enables.
  - goes to ACCESS.
  - no request: stays in IDLE.
- ACCESS:
  - drives the latched transaction for ACCESS_CYCLES cycles (cycle counter 0..ACCESS_CYCLES-1).
  - On the edge ending the last cycle: captures Sram_DataIn into the owner's RData register (reads only; RData holds otherwise) and goes to DONE.
- DONE:
  - owner's Ack = 1 for exactly this cycle; SRAM bus returns to idle values.
  - Next state IDLE.
  - Requesters drop Req on the edge after seeing Ack.

Arbitration (evaluated in IDLE only):
- Only one requester: it wins.
- Both requesting: Gfx wins if VSync_L = 0 or wait_cnt ≥ GFX_MAX_WAIT; otherwise VGA wins.

Starvation counter (wait_cnt):
- Increments in each IDLE cycle where Gfx_Req = 1 and Gfx is not granted; saturates at GFX_MAX_WAIT.
- Clears when Gfx is granted.
- Width: $clog2(GFX_MAX_WAIT+1).

SRAM bus:
- Idle values (IDLE and DONE): Sram_RW_Out = 1, Sram_UDS_Out_L = Sram_LDS_Out_L = 1, Sram_AddressOut = 0, Sram_DataOut = 0.
- VGA access: RW = 1, both byte enables 0.
- Gfx access: RW, byte enables and data taken from the latched request.
- Gfx_Req with both byte enables high: still runs a full access and acknowledges (no-op write/read).

Requester rules:
- Request inputs change while Req is held and before Ack: ignored (values are latched at grant).
- Req deasserted mid-access: access still completes and Ack still pulses.

## Timing
- Latency, Req seen in IDLE → Ack: ACCESS_CYCLES + 1 cycles (grant edge, ACCESS_CYCLES access cycles, DONE).
- Throughput: one access per ACCESS_CYCLES + 2 cycles; no back-to-back grants without an IDLE cycle.
- All outputs are registered.
- Reset values: state IDLE; wait_cnt 0; Ack outputs 0; RData 0; SRAM outputs at idle values.
- Reset asserted mid-ACCESS: next cycle in IDLE with bus idle; no Ack issued for the aborted access.

## Structure
- Package frame_buffer_sram_pkg:
  - state enum {IDLE, ACCESS, DONE};
  - owner enum {OWN_VGA, OWN_GFX};
  - widths: SRAM_ADDR_W = 18, SRAM_DATA_W = 16.
- Single module; no sub-module. Arbitration and counters are small enough to keep inline.

## Test plan
- Single VGA read: ACCESS_CYCLES = 2, Vga_Addr 0x00010, Sram_DataIn 0xBEEF → Sram_AddressOut 0x00010 with RW = 1 for 2 cycles; Vga_Ack pulses 3 cycles after grant with Vga_RData = 0xBEEF.
- Gfx byte write: Addr 0x3FFFF, WData 0x12AB, UDS_L = 1, LDS_L = 0 → Sram_RW_Out = 0, UDS_L = 1, LDS_L = 0, DataOut 0x12AB for 2 cycles; Gfx_Ack pulses once; Gfx_RData unchanged.
- Contention, VSync_L = 1, both requesters held continuously → VGA wins until wait_cnt reaches 8, then Gfx is granted; wait_cnt then reads 0.
- Contention, VSync_L = 0 → Gfx wins the first arbitration.
- Reset asserted in the 2nd ACCESS cycle of a Gfx write → next cycle: IDLE, bus idle, no Gfx_Ack; re-presented request completes normally.
- ACCESS_CYCLES = 1 → one access every 3 cycles under continuous VGA requests.

Source files
------------

// File: rtl/frame_buffer_sram_pkg.sv
// Shared types for the frame-buffer SRAM arbiter.
// Bus states, owners and SRAM bus bundle.
package frame_buffer_sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    OWN_VGA,
    OWN_GFX
  } owner_t;

  typedef struct packed {
    logic                   rw;
    logic                   uds_l;
    logic                   lds_l;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_bus_t;

  function automatic sram_bus_t bus_idle();
    sram_bus_t b;
    b.rw    = 1'b1;
    b.uds_l = 1'b1;
    b.lds_l = 1'b1;
    b.addr  = '0;
    b.wdata = '0;
    return b;
  endfunction

endpackage

// File: rtl/frame_buffer_sram_arbiter.sv
// Frame-buffer SRAM arbiter: VGA fetch vs drawing engine.
// Fixed-length bus cycles, VGA priority, Gfx starvation bound.
module frame_buffer_sram_arbiter
  import frame_buffer_sram_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int GFX_MAX_WAIT  = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   VSync_L,
  input  logic                   Vga_Req,
  input  logic [SRAM_ADDR_W-1:0] Vga_Addr,
  output logic                   Vga_Ack,
  output logic [SRAM_DATA_W-1:0] Vga_RData,
  input  logic                   Gfx_Req,
  input  logic                   Gfx_RW,
  input  logic [SRAM_ADDR_W-1:0] Gfx_Addr,
  input  logic [SRAM_DATA_W-1:0] Gfx_WData,
  input  logic                   Gfx_UDS_L,
  input  logic                   Gfx_LDS_L,
  output logic                   Gfx_Ack,
  output logic [SRAM_DATA_W-1:0] Gfx_RData,
  output logic [SRAM_ADDR_W-1:0] Sram_AddressOut,
  output logic [SRAM_DATA_W-1:0] Sram_DataOut,
  input  logic [SRAM_DATA_W-1:0] Sram_DataIn,
  output logic                   Sram_UDS_Out_L,
  output logic                   Sram_LDS_Out_L,
  output logic                   Sram_RW_Out
);

  localparam int CNT_W  = $clog2(ACCESS_CYCLES + 1);
  localparam int WAIT_W = $clog2(GFX_MAX_WAIT + 1);

  state_t            state;
  state_t            next_state;
  owner_t            owner;
  sram_bus_t         bus;
  logic [CNT_W-1:0]  cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              gfx_win;
  logic              vga_win;
  logic              last;
  logic              wait_sat;

  assign last     = (cnt == CNT_W'(ACCESS_CYCLES - 1));
  assign wait_sat = (wait_cnt >= WAIT_W'(GFX_MAX_WAIT));

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    gfx_win    = 1'b0;
    vga_win    = 1'b0;
    unique case (state)
      IDLE: begin
        gfx_win = Gfx_Req &&
                  (!Vga_Req || !VSync_L || wait_sat);
        vga_win = Vga_Req && !gfx_win;
        if (gfx_win || vga_win)
          next_state = ACCESS;
      end
      ACCESS: if (last) next_state = DONE;
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      owner     <= OWN_VGA;
      bus       <= bus_idle();
      cnt       <= '0;
      wait_cnt  <= '0;
      Vga_Ack   <= 1'b0;
      Gfx_Ack   <= 1'b0;
      Vga_RData <= '0;
      Gfx_RData <= '0;
    end else begin
      Vga_Ack <= 1'b0;
      Gfx_Ack <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (gfx_win) begin
            owner    <= OWN_GFX;
            wait_cnt <= '0;
            bus      <= '{rw:    Gfx_RW,
                          uds_l: Gfx_UDS_L,
                          lds_l: Gfx_LDS_L,
                          addr:  Gfx_Addr,
                          wdata: Gfx_WData};
          end else if (vga_win) begin
            owner <= OWN_VGA;
            bus   <= '{rw:    1'b1,
                       uds_l: 1'b0,
                       lds_l: 1'b0,
                       addr:  Vga_Addr,
                       wdata: '0};
          end
          if (Gfx_Req && !gfx_win && !wait_sat)
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            bus <= bus_idle();
            if (owner == OWN_VGA) begin
              Vga_Ack   <= 1'b1;
              Vga_RData <= Sram_DataIn;
            end else begin
              Gfx_Ack <= 1'b1;
              // writes leave the last read value in place
              if (bus.rw) Gfx_RData <= Sram_DataIn;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign Sram_AddressOut = bus.addr;
  assign Sram_DataOut    = bus.wdata;
  assign Sram_RW_Out     = bus.rw;
  assign Sram_UDS_Out_L  = bus.uds_l;
  assign Sram_LDS_Out_L  = bus.lds_l;

endmodule

// File: tb/tb_frame_buffer_sram_arbiter.sv
// Directed bench for frame_buffer_sram_arbiter.
// Main instance uses defaults; second uses ACCESS_CYCLES = 1.
module tb_frame_buffer_sram_arbiter;
  import frame_buffer_sram_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync_l = 1'b1;
  logic        vga_req = 1'b0;
  logic [17:0] vga_addr = '0;
  logic        vga_ack;
  logic [15:0] vga_rdata;
  logic        gfx_req = 1'b0;
  logic        gfx_rw = 1'b1;
  logic [17:0] gfx_addr = '0;
  logic [15:0] gfx_wdata = '0;
  logic        gfx_uds_l = 1'b1;
  logic        gfx_lds_l = 1'b1;
  logic        gfx_ack;
  logic [15:0] gfx_rdata;
  logic [17:0] s_addr;
  logic [15:0] s_dout;
  logic [15:0] s_din = '0;
  logic        s_uds_l, s_lds_l, s_rw;

  logic        b_req = 1'b0;
  logic        b_ack, b_gack;
  logic [15:0] b_rdata, b_grdata, b_dout;
  logic [17:0] b_addr;
  logic        b_uds_l, b_lds_l, b_rw;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  frame_buffer_sram_arbiter #(
    .ACCESS_CYCLES(2),
    .GFX_MAX_WAIT (8)
  ) dut (
    .Clk(clk), .Reset(rst), .VSync_L(vsync_l),
    .Vga_Req(vga_req), .Vga_Addr(vga_addr),
    .Vga_Ack(vga_ack), .Vga_RData(vga_rdata),
    .Gfx_Req(gfx_req), .Gfx_RW(gfx_rw),
    .Gfx_Addr(gfx_addr), .Gfx_WData(gfx_wdata),
    .Gfx_UDS_L(gfx_uds_l), .Gfx_LDS_L(gfx_lds_l),
    .Gfx_Ack(gfx_ack), .Gfx_RData(gfx_rdata),
    .Sram_AddressOut(s_addr), .Sram_DataOut(s_dout),
    .Sram_DataIn(s_din),
    .Sram_UDS_Out_L(s_uds_l), .Sram_LDS_Out_L(s_lds_l),
    .Sram_RW_Out(s_rw)
  );

  frame_buffer_sram_arbiter #(
    .ACCESS_CYCLES(1),
    .GFX_MAX_WAIT (8)
  ) dut1 (
    .Clk(clk), .Reset(rst), .VSync_L(1'b1),
    .Vga_Req(b_req), .Vga_Addr(18'h0_0ABC),
    .Vga_Ack(b_ack), .Vga_RData(b_rdata),
    .Gfx_Req(1'b0), .Gfx_RW(1'b1),
    .Gfx_Addr(18'h0), .Gfx_WData(16'h0),
    .Gfx_UDS_L(1'b1), .Gfx_LDS_L(1'b1),
    .Gfx_Ack(b_gack), .Gfx_RData(b_grdata),
    .Sram_AddressOut(b_addr), .Sram_DataOut(b_dout),
    .Sram_DataIn(16'h0A0A),
    .Sram_UDS_Out_L(b_uds_l), .Sram_LDS_Out_L(b_lds_l),
    .Sram_RW_Out(b_rw)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_is_idle(input string tag);
    chk({tag, "_rw"},   32'(s_rw),    32'd1);
    chk({tag, "_uds"},  32'(s_uds_l), 32'd1);
    chk({tag, "_lds"},  32'(s_lds_l), 32'd1);
    chk({tag, "_addr"}, 32'(s_addr),  32'd0);
    chk({tag, "_dout"}, 32'(s_dout),  32'd0);
  endtask

  int vga_n, gfx_got, wc, wmax, lat, n;
  int ack_at [5];

  initial begin
    tick(); tick();
    chk("rst_vack",  32'(vga_ack),   32'd0);
    chk("rst_gack",  32'(gfx_ack),   32'd0);
    chk("rst_vrd",   32'(vga_rdata), 32'd0);
    chk("rst_grd",   32'(gfx_rdata), 32'd0);
    chk("rst_wait",  32'(dut.wait_cnt), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    bus_is_idle("rst");
    rst = 1'b0;

    // single VGA read
    vga_req = 1'b1; vga_addr = 18'h00010; s_din = 16'hBEEF;
    tick();
    chk("v_addr1", 32'(s_addr), 32'h10);
    chk("v_rw1",   32'(s_rw),   32'd1);
    chk("v_be1",   32'({s_uds_l, s_lds_l}), 32'd0);
    chk("v_ack1",  32'(vga_ack), 32'd0);
    tick();
    chk("v_addr2", 32'(s_addr), 32'h10);
    chk("v_ack2",  32'(vga_ack), 32'd0);
    tick();
    chk("v_ack3",  32'(vga_ack), 32'd1);
    chk("v_rdata", 32'(vga_rdata), 32'hBEEF);
    chk("v_gack",  32'(gfx_ack), 32'd0);
    bus_is_idle("v_done");
    vga_req = 1'b0;
    tick();
    chk("v_ack4",  32'(vga_ack), 32'd0);

    // Gfx byte write, inputs changed mid-access
    gfx_req = 1'b1; gfx_rw = 1'b0; gfx_addr = 18'h3FFFF;
    gfx_wdata = 16'h12AB; gfx_uds_l = 1'b1; gfx_lds_l = 1'b0;
    s_din = 16'h5555;
    tick();
    chk("g_rw",   32'(s_rw),    32'd0);
    chk("g_uds",  32'(s_uds_l), 32'd1);
    chk("g_lds",  32'(s_lds_l), 32'd0);
    chk("g_addr", 32'(s_addr),  32'h3FFFF);
    chk("g_dout", 32'(s_dout),  32'h12AB);
    gfx_wdata = 16'hFFFF; gfx_addr = 18'h0; gfx_lds_l = 1'b1;
    tick();
    chk("g_dout2", 32'(s_dout),  32'h12AB);
    chk("g_addr2", 32'(s_addr),  32'h3FFFF);
    chk("g_lds2",  32'(s_lds_l), 32'd0);
    tick();
    chk("g_ack",  32'(gfx_ack),   32'd1);
    chk("g_rd",   32'(gfx_rdata), 32'd0);
    bus_is_idle("g_done");
    gfx_req = 1'b0;
    tick();
    chk("g_ack_off", 32'(gfx_ack), 32'd0);

    // Gfx read with Req dropped mid-access
    gfx_req = 1'b1; gfx_rw = 1'b1; gfx_addr = 18'h00123;
    gfx_uds_l = 1'b0; gfx_lds_l = 1'b0; s_din = 16'hCAFE;
    tick();
    chk("gr_rw", 32'(s_rw), 32'd1);
    gfx_req = 1'b0;
    tick(); tick();
    chk("gr_ack", 32'(gfx_ack),   32'd1);
    chk("gr_rd",  32'(gfx_rdata), 32'hCAFE);
    tick();

    // no-op access with both byte enables high
    gfx_req = 1'b1; gfx_rw = 1'b0; gfx_addr = 18'h00777;
    gfx_uds_l = 1'b1; gfx_lds_l = 1'b1;
    tick();
    chk("nop_be", 32'({s_uds_l, s_lds_l}), 32'd3);
    tick(); tick();
    chk("nop_ack", 32'(gfx_ack), 32'd1);
    gfx_req = 1'b0;
    tick();

    // contention during active video
    vga_req = 1'b1; vga_addr = 18'h00200;
    gfx_req = 1'b1; gfx_rw = 1'b0; gfx_addr = 18'h01000;
    gfx_wdata = 16'h4242; gfx_uds_l = 1'b0; gfx_lds_l = 1'b0;
    vga_n = 0; gfx_got = 0; wc = -1; wmax = 0;
    for (int i = 0; i < 200 && gfx_got == 0; i++) begin
      tick();
      if (int'(dut.wait_cnt) > wmax) wmax = int'(dut.wait_cnt);
      if (vga_ack) vga_n++;
      if (gfx_ack) begin
        gfx_got = 1;
        wc = int'(dut.wait_cnt);
      end
    end
    chk("ct_gfx_won", 32'(gfx_got), 32'd1);
    chk("ct_vga_wins", 32'(vga_n), 32'd8);
    chk("ct_wait_max", 32'(wmax), 32'd8);
    chk("ct_wait_clr", 32'(wc), 32'd0);
    vga_req = 1'b0; gfx_req = 1'b0;
    tick(); tick();

    // contention in vertical blank
    vsync_l = 1'b0;
    vga_req = 1'b1; gfx_req = 1'b1; gfx_addr = 18'h2AAAA;
    tick();
    chk("vb_rw",   32'(s_rw),   32'd0);
    chk("vb_addr", 32'(s_addr), 32'h2AAAA);
    gfx_got = 0;
    for (int i = 0; i < 10 && gfx_got == 0; i++) begin
      tick();
      chk("vb_no_vack", 32'(vga_ack), 32'd0);
      if (gfx_ack) gfx_got = 1;
    end
    chk("vb_gack", 32'(gfx_got), 32'd1);
    gfx_req = 1'b0;
    n = 0;
    for (int i = 0; i < 10 && n == 0; i++) begin
      tick();
      if (vga_ack) n = 1;
    end
    chk("vb_vack", 32'(n), 32'd1);
    vga_req = 1'b0; vsync_l = 1'b1;
    tick();

    // reset in the 2nd access cycle of a Gfx write
    gfx_req = 1'b1; gfx_rw = 1'b0; gfx_addr = 18'h01234;
    gfx_wdata = 16'h7777;
    tick();
    chk("ra_rw", 32'(s_rw), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ra_state", 32'(dut.state), 32'(IDLE));
    chk("ra_gack",  32'(gfx_ack), 32'd0);
    bus_is_idle("ra");
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      tick();
      if (gfx_ack) lat = i;
    end
    chk("ra_relat", 32'(lat), 32'd3);
    gfx_req = 1'b0;
    tick();

    // ACCESS_CYCLES = 1, continuous VGA requests
    b_req = 1'b1;
    n = 0;
    for (int i = 0; i < 30 && n < 5; i++) begin
      tick();
      if (b_ack) begin
        ack_at[n] = i;
        n++;
      end
    end
    chk("b_acks", 32'(n), 32'd5);
    for (int k = 1; k < 5; k++)
      chk("b_gap", 32'(ack_at[k] - ack_at[k-1]), 32'd3);
    chk("b_rdata", 32'(b_rdata), 32'h0A0A);
    b_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
